issue_dispatch_queue: RTL and testbench
=======================================

ISSUE_DISPATCH_QUEUE -- requirements
Module: issue_dispatch_queue

Interface
REQ-001 SHALL have parameter LANES, default 2, number of decode lanes written per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 8, number of queue entries (power of 2, DEPTH >= 2*LANES).
REQ-003 SHALL have parameter PW, default 128, payload width per instruction (instr, opcode, regs, imm, operands, control bits packed by decode).
REQ-004 SHALL have ports: clk  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: in_valid  in  LANES  per-lane decode valid; lane 0 is oldest.
REQ-007 SHALL have ports: in_payload  in  LANES*PW  lane k occupies bits [k*PW +: PW].
REQ-008 SHALL have ports: in_is_branch  in  LANES  per-lane branch flag.
REQ-009 SHALL have ports: in_ready  out  1  queue accepts a full LANES-wide write this cycle.
REQ-010 SHALL have ports: stall  out  1  fetch/decode hold, equal to ~in_ready.
REQ-011 SHALL have ports: ex_valid  out  1  head entry issuable to EX.
REQ-012 SHALL have ports: ex_payload  out  PW  head entry payload.
REQ-013 SHALL have ports: ex_is_branch  out  1  head entry branch flag.
REQ-014 SHALL have ports: ex_ready  in  1  EX accepts the head entry.
REQ-015 SHALL have ports: br_resolve  in  1  in-flight branch resolved this cycle.
REQ-016 SHALL have ports: br_taken  in  1  resolution outcome, qualified by br_resolve.
REQ-017 SHALL have ports: count  out  $clog2(DEPTH)+1  occupied entries.
REQ-018 SHALL have ports: br_pending  out  1  an issued branch awaits resolution.

Function
REQ-019 SHALL store entries in a circular buffer with head/tail pointers wrapping modulo DEPTH.
REQ-020 SHALL drive in_ready = 1 when (DEPTH - count) >= LANES, else 0 (combinational from count).
REQ-021 SHALL, when in_ready=1, enqueue every lane with in_valid=1 in ascending lane order, compacted into consecutive slots, tail advanced by popcount(in_valid).
REQ-022 SHALL ignore all lanes when in_ready=0; decode holds its data.
REQ-023 SHALL present the head entry on ex_payload/ex_is_branch combinationally (show-ahead); enqueue-to-ex_valid latency 1 cycle on an empty queue.
REQ-024 SHALL drive ex_valid = (count != 0) && !br_pending.
REQ-025 SHALL pop the head when ex_valid && ex_ready; at most one pop per cycle.
REQ-026 SHALL, on simultaneous push and pop, update count by (pushed - popped) in the same edge; full/empty never overflow or underflow.
REQ-027 SHALL set br_pending on the edge where an entry with ex_is_branch=1 pops; one branch in flight maximum.
REQ-028 SHALL, when br_pending && br_resolve && !br_taken, clear br_pending; issue resumes next cycle with queue contents intact.
REQ-029 SHALL, when br_pending && br_resolve && br_taken, clear br_pending, set head=tail, count=0, and discard any same-cycle push.
REQ-030 SHALL ignore br_resolve when br_pending=0.
REQ-031 SHALL continue accepting pushes while br_pending=1 (speculative fill) subject to REQ-020.
REQ-032 SHALL apply priority rst > taken flush > push/pop.

Reset
REQ-033 SHALL on rst=1 at a clock edge set head=0, tail=0, count=0, br_pending=0; hence ex_valid=0, in_ready=1, stall=0.
REQ-034 SHALL on rst mid-operation discard all entries and any pending branch; inputs in that cycle are ignored.

Verification (LANES=2, DEPTH=8)
REQ-035 SHALL verify: reset, push A,B (in_valid=2'b11), ex_ready=1 -> ex_valid next cycle, A then B issued on consecutive cycles, count 2->1->0.
REQ-036 SHALL verify: ex_ready=0, push 2 per cycle 3 cycles -> count=6, in_ready=1; 4th push -> count=8, in_ready=0, stall=1; 5th push ignored, count stays 8.
REQ-037 SHALL verify: in_valid=2'b10 with payload C in lane 1 -> C stored in one slot, count +1, next issue is C.
REQ-038 SHALL verify: branch BR issued then X,Y queued -> ex_valid=0 while br_pending; br_resolve=1, br_taken=0 -> X issued next cycle.
REQ-039 SHALL verify: same as REQ-038 but br_taken=1 with simultaneous push -> count=0, pushed data dropped, ex_valid=0 next cycle.
REQ-040 SHALL verify: wrap-around, 20 pushes/pops with random ex_ready -> issue order equals push order, rst mid-stream -> count=0, br_pending=0.

Source files
------------

// File: rtl/issue_dispatch_queue_if.sv
// Decode-to-issue bus: multi-lane decode writes in, single-entry show-ahead issue out,
// plus branch resolution and occupancy status.
interface issue_dispatch_queue_if #(
    parameter int LANES = 2,
    parameter int DEPTH = 8,
    parameter int PW    = 128
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [LANES-1:0]    in_valid;
    logic [LANES*PW-1:0] in_payload;
    logic [LANES-1:0]    in_is_branch;
    logic                in_ready;
    logic                stall;
    logic                ex_valid;
    logic [PW-1:0]       ex_payload;
    logic                ex_is_branch;
    logic                ex_ready;
    logic                br_resolve;
    logic                br_taken;
    logic [CW-1:0]       count;
    logic                br_pending;

    modport master (
        output in_valid, in_payload, in_is_branch, ex_ready, br_resolve, br_taken,
        input  in_ready, stall, ex_valid, ex_payload, ex_is_branch, count, br_pending
    );

    modport slave (
        input  in_valid, in_payload, in_is_branch, ex_ready, br_resolve, br_taken,
        output in_ready, stall, ex_valid, ex_payload, ex_is_branch, count, br_pending
    );
endinterface

// File: rtl/issue_dispatch_queue.sv
// Circular issue queue between decode and EX: compacting multi-lane enqueue, one issue
// per cycle, and a single in-flight branch that blocks issue until it resolves.
module issue_dispatch_queue #(
    parameter int LANES = 2,
    parameter int DEPTH = 8,
    parameter int PW    = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    issue_dispatch_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          br_pending_q, br_pending_d;

    logic [PW-1:0] mem_q    [DEPTH];
    logic [PW-1:0] mem_d    [DEPTH];
    logic          br_mem_q [DEPTH];
    logic          br_mem_d [DEPTH];

    logic          in_ready;
    logic          ex_valid;
    logic          pop;
    logic          flush;
    logic [CW-1:0] npush;
    logic [AW-1:0] wr_ptr;

    // Write admission only depends on free space, never on this cycle's pop.
    assign in_ready = (CW'(DEPTH) - count_q) >= CW'(LANES);
    assign ex_valid = (count_q != '0) && !br_pending_q;
    assign pop      = ex_valid && q.ex_ready;
    assign flush    = br_pending_q && q.br_resolve && q.br_taken;

    assign q.in_ready     = in_ready;
    assign q.stall        = ~in_ready;
    assign q.ex_valid     = ex_valid;
    assign q.ex_payload   = mem_q[head_q];
    assign q.ex_is_branch = br_mem_q[head_q];
    assign q.count        = count_q;
    assign q.br_pending   = br_pending_q;

    always_comb begin
        mem_d        = mem_q;
        br_mem_d     = br_mem_q;
        npush        = '0;
        wr_ptr       = '0;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        br_pending_d = br_pending_q;

        // Valid lanes are packed into consecutive slots, lane 0 first.
        for (int i = 0; i < LANES; i++) begin
            if (in_ready && q.in_valid[i] && !flush) begin
                wr_ptr           = tail_q + npush[AW-1:0];
                mem_d[wr_ptr]    = q.in_payload[i*PW +: PW];
                br_mem_d[wr_ptr] = q.in_is_branch[i];
                npush            = npush + CW'(1);
            end
        end

        if (flush) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            tail_d  = tail_q + npush[AW-1:0];
            head_d  = head_q + AW'(pop);
            count_d = count_q + npush - CW'(pop);
        end

        if (br_pending_q && q.br_resolve) begin
            br_pending_d = 1'b0;
        end else if (pop && br_mem_q[head_q]) begin
            br_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            br_pending_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            br_pending_q <= br_pending_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        mem_q    <= mem_d;
        br_mem_q <= br_mem_d;
    end
endmodule

// File: tb/tb_issue_dispatch_queue.sv
// Scoreboard bench for issue_dispatch_queue (LANES=2, DEPTH=8): directed pushes queue
// expected issues, a negedge monitor compares every issued entry in order.
module tb_issue_dispatch_queue;
    localparam int LANES = 2;
    localparam int DEPTH = 8;
    localparam int PW    = 128;

    typedef struct packed {
        logic [PW-1:0] pl;
        logic          br;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];

    issue_dispatch_queue_if #(.LANES(LANES), .DEPTH(DEPTH), .PW(PW)) bus ();

    issue_dispatch_queue #(.LANES(LANES), .DEPTH(DEPTH), .PW(PW)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [PW-1:0] mk(input int t);
        return {96'h0, 32'(t)};
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] v, input int t0, input logic b0,
                        input int t1, input logic b1, input bit accept);
        bus.in_valid     = v;
        bus.in_payload   = {mk(t1), mk(t0)};
        bus.in_is_branch = {b1, b0};
        if (accept) begin
            if (v[0]) sb.push_back({mk(t0), b0});
            if (v[1]) sb.push_back({mk(t1), b1});
        end
        tick();
        bus.in_valid = '0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (bus.count != 0 && n < 50) begin
            tick();
            n++;
        end
        check(name, PW'(bus.count), PW'(0));
    endtask

    // Monitor: every issue handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.ex_valid && bus.ex_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL issue: unexpected entry %0h, scoreboard empty", bus.ex_payload);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("issue payload", bus.ex_payload, e.pl);
                check("issue is_branch", PW'(bus.ex_is_branch), PW'(e.br));
            end
        end
    end

    initial begin
        int pushed;
        int tag;
        int n;

        bus.in_valid     = '0;
        bus.in_payload   = '0;
        bus.in_is_branch = '0;
        bus.ex_ready     = 1'b0;
        bus.br_resolve   = 1'b0;
        bus.br_taken     = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check("reset count", PW'(bus.count), PW'(0));
        check("reset ex_valid", PW'(bus.ex_valid), PW'(0));
        check("reset in_ready", PW'(bus.in_ready), PW'(1));
        check("reset stall", PW'(bus.stall), PW'(0));
        check("reset br_pending", PW'(bus.br_pending), PW'(0));

        // Two-lane write, back-to-back issue
        bus.ex_ready = 1'b1;
        push(2'b11, 1, 1'b0, 2, 1'b0, 1'b1);
        check("t1 count after push", PW'(bus.count), PW'(2));
        check("t1 ex_valid", PW'(bus.ex_valid), PW'(1));
        tick();
        check("t1 count after A", PW'(bus.count), PW'(1));
        tick();
        check("t1 count after B", PW'(bus.count), PW'(0));
        check("t1 ex_valid empty", PW'(bus.ex_valid), PW'(0));

        // Fill to full, over-full write is dropped
        bus.ex_ready = 1'b0;
        push(2'b11, 3, 1'b0, 4, 1'b0, 1'b1);
        push(2'b11, 5, 1'b0, 6, 1'b0, 1'b1);
        push(2'b11, 7, 1'b0, 8, 1'b0, 1'b1);
        check("t2 count 6", PW'(bus.count), PW'(6));
        check("t2 in_ready at 6", PW'(bus.in_ready), PW'(1));
        push(2'b11, 9, 1'b0, 10, 1'b0, 1'b1);
        check("t2 count 8", PW'(bus.count), PW'(8));
        check("t2 in_ready full", PW'(bus.in_ready), PW'(0));
        check("t2 stall full", PW'(bus.stall), PW'(1));
        push(2'b11, 11, 1'b0, 12, 1'b0, 1'b0);
        check("t2 count held", PW'(bus.count), PW'(8));
        bus.ex_ready = 1'b1;
        wait_empty("t2 drain");

        // Single upper lane compacts into one slot
        bus.ex_ready = 1'b0;
        push(2'b10, 'hdead, 1'b0, 13, 1'b0, 1'b0);
        sb.push_back({mk(13), 1'b0});
        check("t3 count", PW'(bus.count), PW'(1));
        check("t3 head", bus.ex_payload, mk(13));
        bus.ex_ready = 1'b1;
        tick();
        check("t3 count after issue", PW'(bus.count), PW'(0));

        // Branch not taken: issue blocks, then resumes with contents intact
        bus.ex_ready = 1'b0;
        push(2'b11, 20, 1'b1, 21, 1'b0, 1'b1);
        push(2'b01, 22, 1'b0, 0, 1'b0, 1'b1);
        check("t4 count 3", PW'(bus.count), PW'(3));
        bus.ex_ready = 1'b1;
        tick();
        check("t4 br_pending", PW'(bus.br_pending), PW'(1));
        check("t4 ex_valid blocked", PW'(bus.ex_valid), PW'(0));
        check("t4 count 2", PW'(bus.count), PW'(2));
        tick();
        check("t4 still blocked", PW'(bus.ex_valid), PW'(0));
        bus.br_resolve = 1'b1;
        bus.br_taken   = 1'b0;
        tick();
        bus.br_resolve = 1'b0;
        check("t4 br cleared", PW'(bus.br_pending), PW'(0));
        check("t4 ex_valid resumes", PW'(bus.ex_valid), PW'(1));
        check("t4 count kept", PW'(bus.count), PW'(2));
        wait_empty("t4 drain");

        // Branch taken: flush, same-cycle push discarded
        bus.ex_ready = 1'b0;
        push(2'b11, 30, 1'b1, 31, 1'b0, 1'b1);
        push(2'b01, 32, 1'b0, 0, 1'b0, 1'b1);
        bus.ex_ready = 1'b1;
        tick();
        check("t5 br_pending", PW'(bus.br_pending), PW'(1));
        bus.br_resolve = 1'b1;
        bus.br_taken   = 1'b1;
        sb.delete();
        push(2'b11, 33, 1'b0, 34, 1'b0, 1'b0);
        bus.br_resolve = 1'b0;
        bus.br_taken   = 1'b0;
        check("t5 flush count", PW'(bus.count), PW'(0));
        check("t5 flush br_pending", PW'(bus.br_pending), PW'(0));
        check("t5 flush ex_valid", PW'(bus.ex_valid), PW'(0));
        tick();
        check("t5 count stays 0", PW'(bus.count), PW'(0));
        check("t5 ex_valid stays 0", PW'(bus.ex_valid), PW'(0));

        // Wrap-around stream with random issue back-pressure
        pushed = 0;
        tag    = 40;
        n      = 0;
        while (pushed < 20 && n < 200) begin
            bus.ex_ready     = 1'($urandom_range(0, 1));
            bus.in_valid     = 2'b11;
            bus.in_payload   = {mk(tag + 1), mk(tag)};
            bus.in_is_branch = 2'b00;
            if (bus.in_ready) begin
                sb.push_back({mk(tag), 1'b0});
                sb.push_back({mk(tag + 1), 1'b0});
                pushed += 2;
                tag    += 2;
            end
            tick();
            n++;
        end
        bus.in_valid = '0;
        check("t6 pushed", PW'(pushed), PW'(20));
        bus.ex_ready = 1'b1;
        wait_empty("t6 drain");

        // Reset mid-stream with a branch in flight and a write presented
        bus.ex_ready = 1'b0;
        push(2'b11, 60, 1'b1, 61, 1'b0, 1'b1);
        bus.ex_ready = 1'b1;
        tick();
        check("t6 br_pending before rst", PW'(bus.br_pending), PW'(1));
        rst = 1'b1;
        sb.delete();
        push(2'b11, 62, 1'b0, 63, 1'b0, 1'b0);
        rst = 1'b0;
        check("t6 rst count", PW'(bus.count), PW'(0));
        check("t6 rst br_pending", PW'(bus.br_pending), PW'(0));
        check("t6 rst ex_valid", PW'(bus.ex_valid), PW'(0));
        check("t6 rst in_ready", PW'(bus.in_ready), PW'(1));
        check("t6 rst stall", PW'(bus.stall), PW'(0));
        tick();
        check("outstanding expectations", PW'(sb.size()), PW'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
